// File: rtl/floo_hbm_arb_pkg.sv
// Shared types and helpers for the HBM port arbiter: arbiter state encoding,
// select-width helper and the round-robin pick function.
package floo_hbm_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MaxReq = 32;

  function automatic int unsigned sel_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // First valid index at or after ptr, wrapping at num_req; returns ptr if none valid.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [MaxReq-1:0] valid,
                                          input int unsigned num_req);
    int unsigned idx;
    int unsigned res;
    res = ptr;
    for (int unsigned i = MaxReq; i > 0; i--) begin
      if (i - 1 < num_req) begin
        idx = ptr + i - 1;
        if (idx >= num_req) idx = idx - num_req;
        if (valid[idx]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/floo_hbm_rr_lock_arb.sv
// Round-robin arbiter that locks onto its grant while the downstream channel
// back-pressures, prefixing the outgoing ID with the granted requester index.
module floo_hbm_rr_lock_arb
  import floo_hbm_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned SelW     = sel_width(NumReq)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic [NumReq-1:0]                  valid_i,
  output logic [NumReq-1:0]                  ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]     id_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [IdWidth+SelW-1:0]            id_o,
  output logic [DataWidth-1:0]               data_o
);

  arb_state_e        state_q, state_d;
  logic [SelW-1:0]   ptr_q, ptr_d;
  logic [SelW-1:0]   grant_q, grant_d;
  logic [SelW-1:0]   pick;
  logic [SelW-1:0]   sel;
  logic [MaxReq-1:0] valid_ext;

  always_comb begin
    valid_ext               = '0;
    valid_ext[NumReq-1:0]   = valid_i;
    pick                    = SelW'(rr_next(32'(ptr_q), valid_ext, NumReq));
    state_d                 = state_q;
    ptr_d                   = ptr_q;
    grant_d                 = grant_q;
    valid_o                 = 1'b0;
    ready_o                 = '0;
    sel                     = pick;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (en_i && (|valid_i)) valid_o = 1'b1;
        end
        LOCKED: begin
          valid_o = 1'b1;
          sel     = grant_q;
        end
        default: ;
      endcase
    end
    // A stalled grant is frozen until the handshake so the request stays AXI-stable.
    if (valid_o && ready_i) begin
      ready_o[sel] = 1'b1;
      ptr_d        = (32'(sel) == NumReq - 1) ? '0 : sel + SelW'(1);
      state_d      = IDLE;
    end else if (valid_o) begin
      grant_d = sel;
      state_d = LOCKED;
    end
  end

  assign id_o   = {sel, id_i[sel]};
  assign data_o = data_i[sel];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: rtl/floo_hbm_port_arbiter.sv
// Shares one HBM AXI channel between NumReq requesters: RR AW/AR, W in AW order,
// B/R demuxed by ID prefix. Define FLOO_HBM_ARB_PERF_EN for per-requester grant counters.
module floo_hbm_port_arbiter
  import floo_hbm_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned AwWidth  = 64,
  parameter int unsigned ArWidth  = 64,
  parameter int unsigned WWidth   = 576,
  parameter int unsigned BWidth   = 2,
  parameter int unsigned RWidth   = 514,
  parameter int unsigned MaxWrTxn = 8,
  localparam int unsigned SelW    = sel_width(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
`ifdef FLOO_HBM_ARB_PERF_EN
  output logic [NumReq-1:0][31:0]          perf_aw_cnt_o,
  output logic [NumReq-1:0][31:0]          perf_ar_cnt_o,
`endif
  input  logic [NumReq-1:0]                req_aw_valid_i,
  output logic [NumReq-1:0]                req_aw_ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]   req_aw_id_i,
  input  logic [NumReq-1:0][AwWidth-1:0]   req_aw_data_i,
  input  logic [NumReq-1:0]                req_w_valid_i,
  output logic [NumReq-1:0]                req_w_ready_o,
  input  logic [NumReq-1:0]                req_w_last_i,
  input  logic [NumReq-1:0][WWidth-1:0]    req_w_data_i,
  output logic [NumReq-1:0]                req_b_valid_o,
  input  logic [NumReq-1:0]                req_b_ready_i,
  output logic [IdWidth-1:0]               req_b_id_o,
  output logic [BWidth-1:0]                req_b_data_o,
  input  logic [NumReq-1:0]                req_ar_valid_i,
  output logic [NumReq-1:0]                req_ar_ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]   req_ar_id_i,
  input  logic [NumReq-1:0][ArWidth-1:0]   req_ar_data_i,
  output logic [NumReq-1:0]                req_r_valid_o,
  input  logic [NumReq-1:0]                req_r_ready_i,
  output logic [IdWidth-1:0]               req_r_id_o,
  output logic [RWidth-1:0]                req_r_data_o,
  output logic                             req_r_last_o,
  output logic                             hbm_aw_valid_o,
  input  logic                             hbm_aw_ready_i,
  output logic [IdWidth+SelW-1:0]          hbm_aw_id_o,
  output logic [AwWidth-1:0]               hbm_aw_data_o,
  output logic                             hbm_w_valid_o,
  input  logic                             hbm_w_ready_i,
  output logic                             hbm_w_last_o,
  output logic [WWidth-1:0]                hbm_w_data_o,
  input  logic                             hbm_b_valid_i,
  output logic                             hbm_b_ready_o,
  input  logic [IdWidth+SelW-1:0]          hbm_b_id_i,
  input  logic [BWidth-1:0]                hbm_b_data_i,
  output logic                             hbm_ar_valid_o,
  input  logic                             hbm_ar_ready_i,
  output logic [IdWidth+SelW-1:0]          hbm_ar_id_o,
  output logic [ArWidth-1:0]               hbm_ar_data_o,
  input  logic                             hbm_r_valid_i,
  output logic                             hbm_r_ready_o,
  input  logic                             hbm_r_last_i,
  input  logic [IdWidth+SelW-1:0]          hbm_r_id_i,
  input  logic [RWidth-1:0]                hbm_r_data_i
);

  localparam int unsigned FifoAw = (MaxWrTxn > 1) ? $clog2(MaxWrTxn) : 1;

  logic                            fifo_full, fifo_empty;
  logic                            aw_hs, push, pop;
  logic [SelW-1:0]                 aw_grant, w_head;
  logic [MaxWrTxn-1:0][SelW-1:0]   fifo_mem_q;
  logic [FifoAw-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FifoAw:0]                 cnt_q, cnt_d;
  logic [SelW-1:0]                 b_idx, r_idx;
  logic                            b_idx_ok, r_idx_ok;

  floo_hbm_rr_lock_arb #(
    .NumReq   (NumReq),
    .IdWidth  (IdWidth),
    .DataWidth(AwWidth)
  ) i_aw_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (!fifo_full),
    .valid_i(req_aw_valid_i),
    .ready_o(req_aw_ready_o),
    .id_i   (req_aw_id_i),
    .data_i (req_aw_data_i),
    .valid_o(hbm_aw_valid_o),
    .ready_i(hbm_aw_ready_i),
    .id_o   (hbm_aw_id_o),
    .data_o (hbm_aw_data_o)
  );

  floo_hbm_rr_lock_arb #(
    .NumReq   (NumReq),
    .IdWidth  (IdWidth),
    .DataWidth(ArWidth)
  ) i_ar_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .valid_i(req_ar_valid_i),
    .ready_o(req_ar_ready_o),
    .id_i   (req_ar_id_i),
    .data_i (req_ar_data_i),
    .valid_o(hbm_ar_valid_o),
    .ready_i(hbm_ar_ready_i),
    .id_o   (hbm_ar_id_o),
    .data_o (hbm_ar_data_o)
  );

  assign aw_hs      = hbm_aw_valid_o & hbm_aw_ready_i;
  assign aw_grant   = hbm_aw_id_o[IdWidth +: SelW];
  assign fifo_full  = (cnt_q == (FifoAw+1)'(MaxWrTxn));
  assign fifo_empty = (cnt_q == '0);
  assign w_head     = fifo_mem_q[rd_ptr_q];
  assign push       = aw_hs;
  assign pop        = hbm_w_valid_o & hbm_w_ready_i & hbm_w_last_o;

  // W is routed only from the FIFO head, so a grant pushed this cycle is seen next cycle.
  always_comb begin
    hbm_w_valid_o = 1'b0;
    req_w_ready_o = '0;
    hbm_w_data_o  = req_w_data_i[w_head];
    hbm_w_last_o  = req_w_last_i[w_head];
    if (!rst_i && !fifo_empty) begin
      hbm_w_valid_o         = req_w_valid_i[w_head];
      req_w_ready_o[w_head] = hbm_w_ready_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (32'(wr_ptr_q) == MaxWrTxn - 1) ? '0 : wr_ptr_q + FifoAw'(1);
    if (pop)  rd_ptr_d = (32'(rd_ptr_q) == MaxWrTxn - 1) ? '0 : rd_ptr_q + FifoAw'(1);
    if (push && !pop)      cnt_d = cnt_q + (FifoAw+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (FifoAw+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= aw_grant;
  end

  assign b_idx    = hbm_b_id_i[IdWidth +: SelW];
  assign r_idx    = hbm_r_id_i[IdWidth +: SelW];
  assign b_idx_ok = (32'(b_idx) < NumReq);
  assign r_idx_ok = (32'(r_idx) < NumReq);

  // Responses to a non-existent requester are swallowed so the HBM side never stalls.
  always_comb begin
    req_b_valid_o = '0;
    req_r_valid_o = '0;
    hbm_b_ready_o = 1'b0;
    hbm_r_ready_o = 1'b0;
    if (!rst_i) begin
      if (b_idx_ok) begin
        req_b_valid_o[b_idx] = hbm_b_valid_i;
        hbm_b_ready_o        = req_b_ready_i[b_idx];
      end else begin
        hbm_b_ready_o = 1'b1;
      end
      if (r_idx_ok) begin
        req_r_valid_o[r_idx] = hbm_r_valid_i;
        hbm_r_ready_o        = req_r_ready_i[r_idx];
      end else begin
        hbm_r_ready_o = 1'b1;
      end
    end
  end

  assign req_b_id_o   = hbm_b_id_i[IdWidth-1:0];
  assign req_b_data_o = hbm_b_data_i;
  assign req_r_id_o   = hbm_r_id_i[IdWidth-1:0];
  assign req_r_data_o = hbm_r_data_i;
  assign req_r_last_o = hbm_r_last_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(hbm_b_valid_i && !b_idx_ok)) else $error("B response for out-of-range requester dropped");
      assert (!(hbm_r_valid_i && !r_idx_ok)) else $error("R response for out-of-range requester dropped");
    end
  end

`ifdef FLOO_HBM_ARB_PERF_EN
  logic                    ar_hs;
  logic [SelW-1:0]         ar_grant;
  logic [NumReq-1:0][31:0] perf_aw_cnt_q, perf_ar_cnt_q;

  assign ar_hs    = hbm_ar_valid_o & hbm_ar_ready_i;
  assign ar_grant = hbm_ar_id_o[IdWidth +: SelW];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_aw_cnt_q <= '0;
      perf_ar_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (aw_hs && (32'(aw_grant) == i) && (perf_aw_cnt_q[i] != '1))
          perf_aw_cnt_q[i] <= perf_aw_cnt_q[i] + 32'd1;
        if (ar_hs && (32'(ar_grant) == i) && (perf_ar_cnt_q[i] != '1))
          perf_ar_cnt_q[i] <= perf_ar_cnt_q[i] + 32'd1;
      end
    end
  end

  assign perf_aw_cnt_o = perf_aw_cnt_q;
  assign perf_ar_cnt_o = perf_ar_cnt_q;
`endif

endmodule

// File: tb/tb_floo_hbm_port_arbiter.sv
// Self-checking bench for floo_hbm_port_arbiter: arbitration order, locking,
// W ordering, order-FIFO full, response demux and mid-transaction reset.
module tb_floo_hbm_port_arbiter;

  localparam int NumReq   = 4;
  localparam int IdWidth  = 4;
  localparam int AwWidth  = 64;
  localparam int ArWidth  = 64;
  localparam int WWidth   = 576;
  localparam int BWidth   = 2;
  localparam int RWidth   = 514;
  localparam int MaxWrTxn = 8;
  localparam int SelW     = 2;
  localparam int HIdW     = IdWidth + SelW;

  logic clk_i = 1'b0;
  logic rst_i;
`ifdef FLOO_HBM_ARB_PERF_EN
  logic [NumReq-1:0][31:0] perf_aw_cnt_o, perf_ar_cnt_o;
`endif
  logic [NumReq-1:0]              req_aw_valid_i, req_aw_ready_o;
  logic [NumReq-1:0][IdWidth-1:0] req_aw_id_i;
  logic [NumReq-1:0][AwWidth-1:0] req_aw_data_i;
  logic [NumReq-1:0]              req_w_valid_i, req_w_ready_o, req_w_last_i;
  logic [NumReq-1:0][WWidth-1:0]  req_w_data_i;
  logic [NumReq-1:0]              req_b_valid_o, req_b_ready_i;
  logic [IdWidth-1:0]             req_b_id_o;
  logic [BWidth-1:0]              req_b_data_o;
  logic [NumReq-1:0]              req_ar_valid_i, req_ar_ready_o;
  logic [NumReq-1:0][IdWidth-1:0] req_ar_id_i;
  logic [NumReq-1:0][ArWidth-1:0] req_ar_data_i;
  logic [NumReq-1:0]              req_r_valid_o, req_r_ready_i;
  logic [IdWidth-1:0]             req_r_id_o;
  logic [RWidth-1:0]              req_r_data_o;
  logic                           req_r_last_o;
  logic                           hbm_aw_valid_o, hbm_aw_ready_i;
  logic [HIdW-1:0]                hbm_aw_id_o;
  logic [AwWidth-1:0]             hbm_aw_data_o;
  logic                           hbm_w_valid_o, hbm_w_ready_i, hbm_w_last_o;
  logic [WWidth-1:0]              hbm_w_data_o;
  logic                           hbm_b_valid_i, hbm_b_ready_o;
  logic [HIdW-1:0]                hbm_b_id_i;
  logic [BWidth-1:0]              hbm_b_data_i;
  logic                           hbm_ar_valid_o, hbm_ar_ready_i;
  logic [HIdW-1:0]                hbm_ar_id_o;
  logic [ArWidth-1:0]             hbm_ar_data_o;
  logic                           hbm_r_valid_i, hbm_r_ready_o, hbm_r_last_i;
  logic [HIdW-1:0]                hbm_r_id_i;
  logic [RWidth-1:0]              hbm_r_data_i;

  int checkCount = 0;
  int errorCount = 0;
  int expQ[$];

  floo_hbm_port_arbiter #(
    .NumReq(NumReq), .IdWidth(IdWidth), .AwWidth(AwWidth), .ArWidth(ArWidth),
    .WWidth(WWidth), .BWidth(BWidth), .RWidth(RWidth), .MaxWrTxn(MaxWrTxn)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
`ifdef FLOO_HBM_ARB_PERF_EN
    .perf_aw_cnt_o(perf_aw_cnt_o), .perf_ar_cnt_o(perf_ar_cnt_o),
`endif
    .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o),
    .req_aw_id_i(req_aw_id_i), .req_aw_data_i(req_aw_data_i),
    .req_w_valid_i(req_w_valid_i), .req_w_ready_o(req_w_ready_o),
    .req_w_last_i(req_w_last_i), .req_w_data_i(req_w_data_i),
    .req_b_valid_o(req_b_valid_o), .req_b_ready_i(req_b_ready_i),
    .req_b_id_o(req_b_id_o), .req_b_data_o(req_b_data_o),
    .req_ar_valid_i(req_ar_valid_i), .req_ar_ready_o(req_ar_ready_o),
    .req_ar_id_i(req_ar_id_i), .req_ar_data_i(req_ar_data_i),
    .req_r_valid_o(req_r_valid_o), .req_r_ready_i(req_r_ready_i),
    .req_r_id_o(req_r_id_o), .req_r_data_o(req_r_data_o), .req_r_last_o(req_r_last_o),
    .hbm_aw_valid_o(hbm_aw_valid_o), .hbm_aw_ready_i(hbm_aw_ready_i),
    .hbm_aw_id_o(hbm_aw_id_o), .hbm_aw_data_o(hbm_aw_data_o),
    .hbm_w_valid_o(hbm_w_valid_o), .hbm_w_ready_i(hbm_w_ready_i),
    .hbm_w_last_o(hbm_w_last_o), .hbm_w_data_o(hbm_w_data_o),
    .hbm_b_valid_i(hbm_b_valid_i), .hbm_b_ready_o(hbm_b_ready_o),
    .hbm_b_id_i(hbm_b_id_i), .hbm_b_data_i(hbm_b_data_i),
    .hbm_ar_valid_o(hbm_ar_valid_o), .hbm_ar_ready_i(hbm_ar_ready_i),
    .hbm_ar_id_o(hbm_ar_id_o), .hbm_ar_data_o(hbm_ar_data_o),
    .hbm_r_valid_i(hbm_r_valid_i), .hbm_r_ready_o(hbm_r_ready_o),
    .hbm_r_last_i(hbm_r_last_i), .hbm_r_id_i(hbm_r_id_i), .hbm_r_data_i(hbm_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic clearInputs();
    req_aw_valid_i = '0; req_w_valid_i = '0; req_w_last_i = '0; req_ar_valid_i = '0;
    req_b_ready_i = '0; req_r_ready_i = '0;
    hbm_aw_ready_i = 1'b0; hbm_w_ready_i = 1'b0; hbm_ar_ready_i = 1'b0;
    hbm_b_valid_i = 1'b0; hbm_r_valid_i = 1'b0; hbm_r_last_i = 1'b0;
    hbm_b_id_i = '0; hbm_b_data_i = '0; hbm_r_id_i = '0; hbm_r_data_i = '0;
    req_w_data_i = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_aw_id_i[i]   = IdWidth'(i + 8);
      req_aw_data_i[i] = AwWidth'(64'hA000 + i);
      req_ar_id_i[i]   = IdWidth'(i + 4);
      req_ar_data_i[i] = ArWidth'(64'hC000 + i);
    end
  endtask

  task automatic doReset();
    clearInputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_i = 1'b1;
    step();
    req_aw_valid_i = '1; req_ar_valid_i = '1; req_w_valid_i = '1;
    hbm_b_valid_i = 1'b1; hbm_r_valid_i = 1'b1; req_b_ready_i = '1; req_r_ready_i = '1;
    hbm_aw_ready_i = 1'b1; hbm_ar_ready_i = 1'b1; hbm_w_ready_i = 1'b1;
    #2;
    checkCount++;
    if ({hbm_aw_valid_o, hbm_ar_valid_o, hbm_w_valid_o} !== 3'b000) begin
      errorCount++;
      $display("[TB] FAIL reset_hbm_valid: got %b expected 000", {hbm_aw_valid_o, hbm_ar_valid_o, hbm_w_valid_o});
    end
    checkCount++;
    if ({req_b_valid_o, req_r_valid_o, req_aw_ready_o, req_ar_ready_o, req_w_ready_o} !== '0) begin
      errorCount++;
      $display("[TB] FAIL reset_req_outputs: got %h expected 0",
               {req_b_valid_o, req_r_valid_o, req_aw_ready_o, req_ar_ready_o, req_w_ready_o});
    end
    checkCount++;
    if ({hbm_b_ready_o, hbm_r_ready_o} !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL reset_resp_ready: got %b expected 00", {hbm_b_ready_o, hbm_r_ready_o});
    end
    doReset();
  endtask

  task automatic test_aw_rr();
    int n, e;
    logic [HIdW-1:0] expId;
    doReset();
    req_aw_valid_i = '1;
    hbm_aw_ready_i = 1'b1;
    expQ.delete();
    for (int g = 0; g < 5; g++) expQ.push_back(g % NumReq);
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      #2;
      checkCount++;
      if (hbm_aw_valid_o !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL aw_rr_valid: got %b expected 1", hbm_aw_valid_o);
      end
      if (hbm_aw_valid_o && hbm_aw_ready_i) begin
        e = expQ.pop_front();
        expId = {SelW'(e), IdWidth'(e + 8)};
        checkCount++;
        if (hbm_aw_id_o !== expId || hbm_aw_data_o !== AwWidth'(64'hA000 + e) ||
            req_aw_ready_o !== NumReq'(1 << e)) begin
          errorCount++;
          $display("[TB] FAIL aw_rr_grant: got id %h data %h ready %b expected id %h data %h ready %b",
                   hbm_aw_id_o, hbm_aw_data_o, req_aw_ready_o, expId, AwWidth'(64'hA000 + e), NumReq'(1 << e));
        end
      end
      step();
      n++;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL aw_rr_timeout: got %0d pending expected 0", expQ.size());
    end
`ifdef FLOO_HBM_ARB_PERF_EN
    checkCount++;
    if (perf_aw_cnt_o[0] !== 32'd2 || perf_aw_cnt_o[3] !== 32'd1) begin
      errorCount++;
      $display("[TB] FAIL perf_aw_cnt: got %0d/%0d expected 2/1", perf_aw_cnt_o[0], perf_aw_cnt_o[3]);
    end
`endif
  endtask

  task automatic test_aw_lock();
    int n, e;
    logic [HIdW-1:0] expId;
    doReset();
    req_aw_valid_i = 4'b0100;
    hbm_aw_ready_i = 1'b0;
    #2;
    checkCount++;
    if (hbm_aw_valid_o !== 1'b1 || hbm_aw_id_o !== {2'd2, 4'hA} || req_aw_ready_o !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL aw_lock_first: got v %b id %h rdy %b expected v 1 id 2a rdy 0000",
               hbm_aw_valid_o, hbm_aw_id_o, req_aw_ready_o);
    end
    step();
    req_aw_valid_i = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      #2;
      checkCount++;
      if (hbm_aw_valid_o !== 1'b1 || hbm_aw_id_o !== {2'd2, 4'hA} ||
          hbm_aw_data_o !== AwWidth'(64'hA002) || req_aw_ready_o !== 4'b0000) begin
        errorCount++;
        $display("[TB] FAIL aw_lock_hold: got v %b id %h data %h rdy %b expected v 1 id 2a data a002 rdy 0000",
                 hbm_aw_valid_o, hbm_aw_id_o, hbm_aw_data_o, req_aw_ready_o);
      end
      step();
    end
    hbm_aw_ready_i = 1'b1;
    expQ.delete();
    expQ.push_back(2); expQ.push_back(3); expQ.push_back(1);
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      #2;
      e = -1;
      if (hbm_aw_valid_o && hbm_aw_ready_i) begin
        e = expQ.pop_front();
        expId = {SelW'(e), IdWidth'(e + 8)};
        checkCount++;
        if (hbm_aw_id_o !== expId || req_aw_ready_o !== NumReq'(1 << e)) begin
          errorCount++;
          $display("[TB] FAIL aw_lock_order: got id %h ready %b expected id %h ready %b",
                   hbm_aw_id_o, req_aw_ready_o, expId, NumReq'(1 << e));
        end
      end
      step();
      if (e >= 0) req_aw_valid_i[e] = 1'b0;
      n++;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL aw_lock_timeout: got %0d pending expected 0", expQ.size());
    end
  endtask

  int beatCnt[NumReq];
  int wLen[NumReq];
  logic [NumReq-1:0] wActive;

  task automatic driveW();
    for (int k = 0; k < NumReq; k++) begin
      req_w_data_i[k]  = WWidth'(k * 256 + beatCnt[k]);
      req_w_last_i[k]  = (beatCnt[k] == wLen[k] - 1);
      req_w_valid_i[k] = wActive[k] && (beatCnt[k] < wLen[k]);
    end
  endtask

  task automatic test_w_order();
    int n, e;
    logic [NumReq-1:0] taken, expRdy;
    doReset();
    for (int k = 0; k < NumReq; k++) begin beatCnt[k] = 0; wLen[k] = 0; end
    wLen[1] = 4; wLen[0] = 1;
    wActive = 4'b0010;
    driveW();
    hbm_aw_ready_i = 1'b1;
    hbm_w_ready_i  = 1'b1;
    req_aw_valid_i = 4'b0010;
    expQ.delete();
    for (int b = 0; b < 4; b++) expQ.push_back(1 * 256 + b + ((b == 3) ? 65536 : 0));
    expQ.push_back(0 * 256 + 0 + 65536);
    #2;
    checkCount++;
    if (hbm_w_valid_o !== 1'b0 || hbm_aw_id_o !== {2'd1, 4'h9} || hbm_aw_valid_o !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL w_no_bypass: got wv %b awv %b awid %h expected wv 0 awv 1 awid 19",
               hbm_w_valid_o, hbm_aw_valid_o, hbm_aw_id_o);
    end
    step();
    req_aw_valid_i = 4'b0001;
    wActive = 4'b0011;
    driveW();
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      #2;
      if (n == 0) begin
        checkCount++;
        if (hbm_aw_valid_o !== 1'b1 || hbm_aw_id_o !== {2'd0, 4'h8}) begin
          errorCount++;
          $display("[TB] FAIL w_second_aw: got v %b id %h expected v 1 id 08", hbm_aw_valid_o, hbm_aw_id_o);
        end
      end
      expRdy = (beatCnt[1] < wLen[1]) ? 4'b0010 : 4'b0001;
      checkCount++;
      if (req_w_ready_o !== expRdy) begin
        errorCount++;
        $display("[TB] FAIL w_ready_route: got %b expected %b", req_w_ready_o, expRdy);
      end
      if (hbm_w_valid_o && hbm_w_ready_i) begin
        e = expQ.pop_front();
        checkCount++;
        if (hbm_w_data_o !== WWidth'(e % 65536) || hbm_w_last_o !== (e >= 65536)) begin
          errorCount++;
          $display("[TB] FAIL w_beat: got data %0h last %b expected data %0h last %b",
                   hbm_w_data_o[31:0], hbm_w_last_o, e % 65536, (e >= 65536));
        end
      end
      taken = req_w_ready_o & req_w_valid_i;
      step();
      req_aw_valid_i = '0;
      for (int k = 0; k < NumReq; k++) if (taken[k]) beatCnt[k]++;
      driveW();
      n++;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL w_order_timeout: got %0d pending expected 0", expQ.size());
    end
    #2;
    checkCount++;
    if (hbm_w_valid_o !== 1'b0 || req_w_ready_o !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL w_drained: got v %b rdy %b expected v 0 rdy 0000", hbm_w_valid_o, req_w_ready_o);
    end
  endtask

  task automatic test_fifo_full();
    int hsCount;
    doReset();
    req_aw_valid_i = 4'b0001;
    hbm_aw_ready_i = 1'b1;
    hbm_w_ready_i  = 1'b1;
    hsCount = 0;
    for (int c = 0; c < MaxWrTxn; c++) begin
      #2;
      if (hbm_aw_valid_o && hbm_aw_ready_i) hsCount++;
      step();
    end
    checkCount++;
    if (hsCount != MaxWrTxn) begin
      errorCount++;
      $display("[TB] FAIL fifo_fill: got %0d handshakes expected %0d", hsCount, MaxWrTxn);
    end
    for (int c = 0; c < 2; c++) begin
      #2;
      checkCount++;
      if (hbm_aw_valid_o !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL fifo_full_block: got %b expected 0", hbm_aw_valid_o);
      end
      step();
    end
    req_w_valid_i[0] = 1'b1;
    req_w_last_i[0]  = 1'b1;
    #2;
    checkCount++;
    if (hbm_w_valid_o !== 1'b1 || hbm_aw_valid_o !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL fifo_pop_cycle: got wv %b awv %b expected wv 1 awv 0", hbm_w_valid_o, hbm_aw_valid_o);
    end
    step();
    req_w_valid_i = '0;
    req_w_last_i  = '0;
    #2;
    checkCount++;
    if (hbm_aw_valid_o !== 1'b1 || hbm_aw_id_o !== {2'd0, 4'h8}) begin
      errorCount++;
      $display("[TB] FAIL fifo_after_pop: got v %b id %h expected v 1 id 08", hbm_aw_valid_o, hbm_aw_id_o);
    end
    step();
  endtask

  task automatic test_resp_demux();
    doReset();
    hbm_r_valid_i = 1'b1;
    hbm_r_id_i    = {2'd3, 4'h5};
    hbm_r_last_i  = 1'b1;
    hbm_r_data_i  = RWidth'(64'h1234_5678_9ABC);
    req_r_ready_i = 4'b1111;
    hbm_b_valid_i = 1'b1;
    hbm_b_id_i    = {2'd1, 4'h9};
    hbm_b_data_i  = 2'b10;
    req_b_ready_i = 4'b0010;
    #2;
    checkCount++;
    if (req_r_valid_o !== 4'b1000 || req_r_id_o !== 4'h5 || req_r_last_o !== 1'b1 ||
        req_r_data_o !== RWidth'(64'h1234_5678_9ABC) || hbm_r_ready_o !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL r_demux: got v %b id %h last %b rdy %b expected v 1000 id 5 last 1 rdy 1",
               req_r_valid_o, req_r_id_o, req_r_last_o, hbm_r_ready_o);
    end
    checkCount++;
    if (req_b_valid_o !== 4'b0010 || req_b_id_o !== 4'h9 || req_b_data_o !== 2'b10 || hbm_b_ready_o !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL b_demux: got v %b id %h data %b rdy %b expected v 0010 id 9 data 10 rdy 1",
               req_b_valid_o, req_b_id_o, req_b_data_o, hbm_b_ready_o);
    end
    req_r_ready_i = 4'b0111;
    req_b_ready_i = 4'b1101;
    #2;
    checkCount++;
    if (hbm_r_ready_o !== 1'b0 || hbm_b_ready_o !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL resp_backpressure: got r %b b %b expected r 0 b 0", hbm_r_ready_o, hbm_b_ready_o);
    end
    step();
    clearInputs();
  endtask

  task automatic test_reset_mid();
    doReset();
    req_aw_valid_i = 4'b0001;
    hbm_aw_ready_i = 1'b1;
    req_ar_valid_i = 4'b0100;
    hbm_ar_ready_i = 1'b1;
    step();
    req_ar_valid_i = 4'b0010;
    hbm_ar_ready_i = 1'b0;
    step();
    step();
    req_aw_valid_i = '0;
    req_w_valid_i[0] = 1'b1;
    #2;
    checkCount++;
    if (hbm_ar_valid_o !== 1'b1 || hbm_ar_id_o !== {2'd1, 4'h5} || hbm_w_valid_o !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL pre_reset_state: got arv %b arid %h wv %b expected arv 1 arid 15 wv 1",
               hbm_ar_valid_o, hbm_ar_id_o, hbm_w_valid_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_ar_valid_i = '0;
    #2;
    checkCount++;
    if ({hbm_ar_valid_o, hbm_aw_valid_o, hbm_w_valid_o} !== 3'b000 || req_w_ready_o !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_clear: got ar/aw/w %b wrdy %b expected 000 0000",
               {hbm_ar_valid_o, hbm_aw_valid_o, hbm_w_valid_o}, req_w_ready_o);
    end
    req_ar_valid_i = 4'b1001;
    req_aw_valid_i = 4'b0011;
    #2;
    checkCount++;
    if (hbm_ar_id_o !== {2'd0, 4'h4} || hbm_aw_id_o !== {2'd0, 4'h8}) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_ptr: got arid %h awid %h expected arid 04 awid 08", hbm_ar_id_o, hbm_aw_id_o);
    end
    step();
    clearInputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_aw_rr();
    test_aw_lock();
    test_w_order();
    test_fifo_full();
    test_resp_demux();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
